// File: rtl/exprom_ctrl_if.sv
// -----------------------------------------------------------------------------
// exprom_ctrl_if
// Bundles every signal of the expansion-ROM controller except clk/rst_n.
//
// Groups:
//   config   : cfg_wr, cfg_wdata, cfg_be -> cfg_rdata (BAR at config 0x30)
//   request  : req, req_addr, req_wr, req_wdata, req_be, prog_en
//              -> hit, busy, ack, rdata
//   rom      : rom_address, rom_enable, rom_wren, rom_dinp -> rom_dout
//              (synchronous 512x32 array owned by the master side)
//
// Modports:
//   master : the host/config side, which also owns the ROM array
//   slave  : the controller (exprom_ctrl)
// -----------------------------------------------------------------------------
interface exprom_ctrl_if;
   // Config-space BAR access
   logic        cfg_wr;
   logic [31:0] cfg_wdata;
   logic [3:0]  cfg_be;
   logic [31:0] cfg_rdata;

   // Memory transaction
   logic        req;
   logic [31:0] req_addr;
   logic        req_wr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        prog_en;
   logic        hit;
   logic        busy;
   logic        ack;
   logic [31:0] rdata;

   // ROM array port
   logic [8:0]  rom_address;
   logic        rom_enable;
   logic        rom_wren;
   logic [31:0] rom_dinp;
   logic [31:0] rom_dout;

   modport master (
      output cfg_wr, cfg_wdata, cfg_be,
      input  cfg_rdata,
      output req, req_addr, req_wr, req_wdata, req_be, prog_en,
      input  hit, busy, ack, rdata,
      input  rom_address, rom_enable, rom_wren, rom_dinp,
      output rom_dout
   );

   modport slave (
      input  cfg_wr, cfg_wdata, cfg_be,
      output cfg_rdata,
      input  req, req_addr, req_wr, req_wdata, req_be, prog_en,
      output hit, busy, ack, rdata,
      output rom_address, rom_enable, rom_wren, rom_dinp,
      input  rom_dout
   );
endinterface : exprom_ctrl_if

// File: rtl/exprom_ctrl.sv
// -----------------------------------------------------------------------------
// exprom_ctrl
// Expansion-ROM BAR decoder and access controller for a synchronous 512x32
// ROM/shadow array.
//
// Ports:
//   clk    : rising-edge clock for all state
//   rst_n  : asynchronous active-low reset
//   bus    : exprom_ctrl_if.slave
//            cfg_*      BAR write / readback ({bar[31:11], 10'b0, bar_en})
//            req_*      one-cycle transaction strobe + address/data/byte-enables
//            prog_en    allows writes into the array (sampled at acceptance)
//            hit        combinational BAR match of req_addr
//            busy/ack   registered status, ack is a one-cycle completion pulse
//            rdata      last read word, valid while ack=1, held otherwise
//            rom_*      registered array controls; rom_dout arrives the cycle
//                       after an enabled edge
//
// Transaction flows (E0 = accepting edge):
//   read          IDLE -> RD -> RD_CAP -> DONE(ack) -> IDLE
//   full write    IDLE -> WR -> DONE(ack) -> IDLE
//   partial write IDLE -> RMW_RD -> RMW_CAP -> WR -> DONE(ack) -> IDLE
//   no-op write   IDLE -> DONE -> DONE(ack) -> IDLE   (no array access)
// -----------------------------------------------------------------------------
module exprom_ctrl (
   input  logic         clk,
   input  logic         rst_n,
   exprom_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD      = 3'd1,
      ST_RD_CAP  = 3'd2,
      ST_RMW_RD  = 3'd3,
      ST_RMW_CAP = 3'd4,
      ST_WR      = 3'd5,
      ST_DONE    = 3'd6
   } state_e;

   // State and registered outputs
   state_e      state_q,       state_d;
   logic [31:11] bar_q,        bar_d;
   logic        bar_en_q,      bar_en_d;
   logic        ack_q,         ack_d;
   logic        busy_q,        busy_d;
   logic [31:0] rdata_q,       rdata_d;
   logic [8:0]  rom_address_q, rom_address_d;
   logic        rom_enable_q,  rom_enable_d;
   logic        rom_wren_q,    rom_wren_d;
   logic [31:0] rom_dinp_q,    rom_dinp_d;

   // Write payload captured at acceptance for the read-modify-write merge
   logic [3:0]  be_q,          be_d;
   logic [31:0] wdata_q,       wdata_d;

   logic        hit;
   logic        accept;
   logic [31:0] merged;

   // -------------------------------------------------------------------------
   // BAR decode: the only combinational outputs besides cfg_rdata
   // -------------------------------------------------------------------------
   assign hit    = bar_en_q && (bus.req_addr[31:11] == bar_q);
   assign accept = bus.req && !busy_q && hit;

   assign bus.hit       = hit;
   assign bus.cfg_rdata = {bar_q, 10'b0, bar_en_q};

   // Byte-lane merge: enabled lanes from the request, the rest from the array
   always_comb begin
      merged = bus.rom_dout;
      for (int i = 0; i < 4; i++) begin
         if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
      end
   end

   // -------------------------------------------------------------------------
   // Next-state / next-output logic
   // -------------------------------------------------------------------------
   // NOTE: every signal assigned below gets a default first, so no path can
   // leave a variable unassigned and infer a latch.
   always_comb begin
      state_d       = state_q;
      bar_d         = bar_q;
      bar_en_d      = bar_en_q;
      rdata_d       = rdata_q;
      rom_address_d = rom_address_q;
      rom_dinp_d    = rom_dinp_q;
      be_d          = be_q;
      wdata_d       = wdata_q;
      ack_d         = 1'b0;
      rom_enable_d  = 1'b0;
      rom_wren_d    = 1'b0;

      // BAR writes land at the next edge independent of the FSM; an
      // in-flight transaction already holds its decoded word index.
      if (bus.cfg_wr) begin
         if (bus.cfg_be[3]) bar_d[31:24] = bus.cfg_wdata[31:24];
         if (bus.cfg_be[2]) bar_d[23:16] = bus.cfg_wdata[23:16];
         if (bus.cfg_be[1]) bar_d[15:11] = bus.cfg_wdata[15:11];
         if (bus.cfg_be[0]) bar_en_d     = bus.cfg_wdata[0];
      end

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               rom_address_d = bus.req_addr[10:2];
               be_d          = bus.req_be;
               wdata_d       = bus.req_wdata;
               if (!bus.req_wr) begin
                  state_d      = ST_RD;
                  rom_enable_d = 1'b1;
               end else if (bus.prog_en && (bus.req_be == 4'hF)) begin
                  state_d      = ST_WR;
                  rom_enable_d = 1'b1;
                  rom_wren_d   = 1'b1;
                  rom_dinp_d   = bus.req_wdata;
               end else if (bus.prog_en && (bus.req_be != 4'h0)) begin
                  state_d      = ST_RMW_RD;
                  rom_enable_d = 1'b1;
               end else begin
                  // Blocked or empty write: complete without touching the array
                  state_d = ST_DONE;
               end
            end
         end

         ST_RD:     state_d = ST_RD_CAP;

         ST_RD_CAP: begin
            rdata_d = bus.rom_dout;
            ack_d   = 1'b1;
            state_d = ST_DONE;
         end

         ST_RMW_RD: state_d = ST_RMW_CAP;

         ST_RMW_CAP: begin
            rom_dinp_d   = merged;
            rom_enable_d = 1'b1;
            rom_wren_d   = 1'b1;
            state_d      = ST_WR;
         end

         ST_WR: begin
            ack_d   = 1'b1;
            state_d = ST_DONE;
         end

         ST_DONE: begin
            // Normal paths enter DONE with ack already set and leave after one
            // cycle. The no-access write enters with ack low, so it spends one
            // extra cycle here to give the same ack latency as a full write.
            if (ack_q) begin
               state_d = ST_IDLE;
            end else begin
               ack_d = 1'b1;
            end
         end

         default:   state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         bar_q         <= '0;
         bar_en_q      <= 1'b0;
         ack_q         <= 1'b0;
         busy_q        <= 1'b0;
         rdata_q       <= '0;
         rom_address_q <= '0;
         rom_enable_q  <= 1'b0;
         rom_wren_q    <= 1'b0;
         rom_dinp_q    <= '0;
         be_q          <= '0;
         wdata_q       <= '0;
      end else begin
         state_q       <= state_d;
         bar_q         <= bar_d;
         bar_en_q      <= bar_en_d;
         ack_q         <= ack_d;
         busy_q        <= busy_d;
         rdata_q       <= rdata_d;
         rom_address_q <= rom_address_d;
         rom_enable_q  <= rom_enable_d;
         rom_wren_q    <= rom_wren_d;
         rom_dinp_q    <= rom_dinp_d;
         be_q          <= be_d;
         wdata_q       <= wdata_d;
      end
   end

   assign bus.ack         = ack_q;
   assign bus.busy        = busy_q;
   assign bus.rdata       = rdata_q;
   assign bus.rom_address = rom_address_q;
   assign bus.rom_enable  = rom_enable_q;
   assign bus.rom_wren    = rom_wren_q;
   assign bus.rom_dinp    = rom_dinp_q;

endmodule : exprom_ctrl

// File: tb/tb_exprom_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exprom_ctrl
// Directed bench for exprom_ctrl. Inputs change on the falling edge and
// outputs are sampled there too, i.e. half a cycle after the active edge.
// The bench owns a 512x32 synchronous array model (read-before-write).
// -----------------------------------------------------------------------------
module tb_exprom_ctrl;

   logic clk;
   logic rst_n;

   exprom_ctrl_if bus ();

   exprom_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Array model plus a preload port so only one process writes mem
   // ---------------------------------------------------------------------------
   logic [31:0] mem [0:511];
   logic        pre_we;
   logic [8:0]  pre_addr;
   logic [31:0] pre_data;

   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      if (bus.rom_enable) begin
         if (bus.rom_wren) mem[bus.rom_address] <= bus.rom_dinp;
         bus.rom_dout <= mem[bus.rom_address];
      end
   end

   // Event monitors
   int ack_cnt  = 0;
   int wren_cnt = 0;
   int bad_cnt  = 0;
   always @(posedge clk) if (bus.ack) ack_cnt++;
   always @(posedge clk) if (bus.rom_wren) wren_cnt++;
   always @(posedge clk) if (bus.rom_wren && !bus.rom_enable) bad_cnt++;

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic load_word(input logic [8:0] a, input logic [31:0] d);
      pre_we   = 1'b1;
      pre_addr = a;
      pre_data = d;
      tick();
      pre_we   = 1'b0;
   endtask

   task automatic cfg_write(input logic [31:0] d, input logic [3:0] be);
      bus.cfg_wr    = 1'b1;
      bus.cfg_wdata = d;
      bus.cfg_be    = be;
      tick();
      bus.cfg_wr    = 1'b0;
   endtask

   // Drive a request strobe; returns after the accepting edge (E0).
   task automatic issue(input logic [31:0] a, input logic wr,
                        input logic [31:0] wd, input logic [3:0] be);
      bus.req       = 1'b1;
      bus.req_addr  = a;
      bus.req_wr    = wr;
      bus.req_wdata = wd;
      bus.req_be    = be;
      tick();
      bus.req       = 1'b0;
   endtask

   // Full read sequence with timing checks on ack/rdata/busy.
   task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
      issue(a, 1'b0, 32'h0, 4'hF);
      check({tag, "_rd_en"}, bus.rom_enable, 1'b1);
      tick();
      tick();
      check({tag, "_ack"},   bus.ack, 1'b1);
      check({tag, "_rdata"}, bus.rdata, exp);
      tick();
      check({tag, "_idle"},  bus.busy, 1'b0);
   endtask

   int a0, w0;

   initial begin
      rst_n         = 1'b0;
      pre_we        = 1'b0;
      pre_addr      = '0;
      pre_data      = '0;
      bus.cfg_wr    = 1'b0;
      bus.cfg_wdata = '0;
      bus.cfg_be    = '0;
      bus.req       = 1'b0;
      bus.req_addr  = '0;
      bus.req_wr    = 1'b0;
      bus.req_wdata = '0;
      bus.req_be    = '0;
      bus.prog_en   = 1'b0;
      bus.rom_dout  = '0;
      tick();
      tick();

      // ---- reset state ------------------------------------------------------
      check("rst_cfg_rdata", bus.cfg_rdata, 32'h0);
      check("rst_busy",      bus.busy, 1'b0);
      check("rst_ack",       bus.ack, 1'b0);
      check("rst_rdata",     bus.rdata, 32'h0);
      check("rst_rom_en",    bus.rom_enable, 1'b0);
      check("rst_rom_addr",  bus.rom_address, 9'd0);
      rst_n = 1'b1;
      tick();

      // ---- BAR programming and byte lanes -----------------------------------
      cfg_write(32'hFFFF_FFFF, 4'hF);
      check("bar_all_ones", bus.cfg_rdata, 32'hFFFF_F801);
      cfg_write(32'h0000_0000, 4'h1);
      check("bar_en_off", bus.cfg_rdata, 32'hFFFF_F800);
      bus.req_addr = 32'hFFFF_F800;
      #1 check("hit_disabled_a", bus.hit, 1'b0);
      bus.req_addr = 32'h0000_0000;
      #1 check("hit_disabled_b", bus.hit, 1'b0);
      cfg_write(32'h0000_0000, 4'b0100);
      check("bar_lane2", bus.cfg_rdata, 32'hFF00_F800);
      cfg_write(32'h0000_0000, 4'b0010);
      check("bar_lane1", bus.cfg_rdata, 32'hFF00_0000);
      cfg_write(32'hC000_0001, 4'hF);
      check("bar_set", bus.cfg_rdata, 32'hC000_0001);
      bus.req_addr = 32'hC000_0014;
      #1 check("hit_in", bus.hit, 1'b1);
      bus.req_addr = 32'hC000_0800;
      #1 check("hit_out", bus.hit, 1'b0);

      // ---- read word 5 ------------------------------------------------------
      load_word(9'd5, 32'hDEAD_BEEF);
      issue(32'hC000_0014, 1'b0, 32'h0, 4'hF);
      check("rd_E0_en",   bus.rom_enable, 1'b1);
      check("rd_E0_wren", bus.rom_wren, 1'b0);
      check("rd_E0_addr", bus.rom_address, 9'd5);
      check("rd_E0_busy", bus.busy, 1'b1);
      check("rd_E0_ack",  bus.ack, 1'b0);
      tick();
      check("rd_E1_en",   bus.rom_enable, 1'b0);
      check("rd_E1_ack",  bus.ack, 1'b0);
      tick();
      check("rd_E2_ack",   bus.ack, 1'b1);
      check("rd_E2_rdata", bus.rdata, 32'hDEAD_BEEF);
      tick();
      check("rd_E3_ack",  bus.ack, 1'b0);
      check("rd_E3_busy", bus.busy, 1'b0);

      // ---- partial write (read-modify-write) --------------------------------
      load_word(9'd5, 32'h1122_3344);
      bus.prog_en = 1'b1;
      w0 = wren_cnt;
      issue(32'hC000_0015, 1'b1, 32'hAABB_CCDD, 4'b0101);
      check("rmw_E0_en",   bus.rom_enable, 1'b1);
      check("rmw_E0_wren", bus.rom_wren, 1'b0);
      tick();
      check("rmw_E1_en",   bus.rom_enable, 1'b0);
      tick();
      check("rmw_E2_wren", bus.rom_wren, 1'b1);
      check("rmw_E2_dinp", bus.rom_dinp, 32'h11BB_33DD);
      check("rmw_E2_ack",  bus.ack, 1'b0);
      tick();
      check("rmw_E3_ack",   bus.ack, 1'b1);
      check("rmw_E3_rdata", bus.rdata, 32'hDEAD_BEEF);
      check("rmw_E3_en",    bus.rom_enable, 1'b0);
      tick();
      check("rmw_E4_busy",  bus.busy, 1'b0);
      check("rmw_wr_count", wren_cnt - w0, 1);
      check("rmw_mem",      mem[5], 32'h11BB_33DD);
      do_read("rmw_readback", 32'hC000_0014, 32'h11BB_33DD);

      // ---- full write; prog_en dropped after acceptance ---------------------
      bus.prog_en = 1'b1;
      issue(32'hC000_000C, 1'b1, 32'h1234_5678, 4'hF);
      bus.prog_en = 1'b0;
      check("fw_E0_wren", bus.rom_wren, 1'b1);
      check("fw_E0_dinp", bus.rom_dinp, 32'h1234_5678);
      check("fw_E0_addr", bus.rom_address, 9'd3);
      tick();
      check("fw_E1_ack",  bus.ack, 1'b1);
      tick();
      check("fw_E2_busy", bus.busy, 1'b0);
      check("fw_mem",     mem[3], 32'h1234_5678);

      // ---- write blocked by prog_en=0 ---------------------------------------
      load_word(9'd7, 32'hCAFE_F00D);
      bus.prog_en = 1'b0;
      w0 = wren_cnt;
      issue(32'hC000_001C, 1'b1, 32'h0BAD_0BAD, 4'hF);
      check("np_E0_busy", bus.busy, 1'b1);
      check("np_E0_ack",  bus.ack, 1'b0);
      check("np_E0_en",   bus.rom_enable, 1'b0);
      tick();
      check("np_E1_ack",  bus.ack, 1'b1);
      check("np_rdata",   bus.rdata, 32'h11BB_33DD);
      tick();
      check("np_E2_ack",  bus.ack, 1'b0);
      check("np_E2_busy", bus.busy, 1'b0);

      // ---- write with be=0 and prog_en=1 ------------------------------------
      bus.prog_en = 1'b1;
      issue(32'hC000_001C, 1'b1, 32'h0BAD_0BAD, 4'h0);
      check("be0_E0_ack", bus.ack, 1'b0);
      tick();
      check("be0_E1_ack", bus.ack, 1'b1);
      tick();
      check("np_wr_count", wren_cnt - w0, 0);
      check("np_mem",      mem[7], 32'hCAFE_F00D);

      // ---- miss -------------------------------------------------------------
      a0 = ack_cnt;
      issue(32'hC000_0800, 1'b0, 32'h0, 4'hF);
      check("miss_busy", bus.busy, 1'b0);
      check("miss_en",   bus.rom_enable, 1'b0);
      tick();
      tick();
      check("miss_acks", ack_cnt - a0, 0);

      // ---- req during busy ignored; BAR disabled mid-read -------------------
      a0 = ack_cnt;
      issue(32'hC000_0014, 1'b0, 32'h0, 4'hF);
      bus.req        = 1'b1;
      bus.req_addr   = 32'hC000_000C;
      bus.cfg_wr     = 1'b1;
      bus.cfg_wdata  = 32'h0;
      bus.cfg_be     = 4'h1;
      tick();
      bus.req        = 1'b0;
      bus.cfg_wr     = 1'b0;
      check("bsy_cfg_rdata", bus.cfg_rdata, 32'hC000_0000);
      tick();
      check("bsy_ack",   bus.ack, 1'b1);
      check("bsy_rdata", bus.rdata, 32'h11BB_33DD);
      tick();
      tick();
      check("bsy_idle",  bus.busy, 1'b0);
      check("bsy_acks",  ack_cnt - a0, 1);
      cfg_write(32'h0000_0001, 4'h1);
      check("bar_reen", bus.cfg_rdata, 32'hC000_0001);

      // ---- reset in RMW_CAP -------------------------------------------------
      load_word(9'd9, 32'h5566_7788);
      a0 = ack_cnt;
      w0 = wren_cnt;
      bus.prog_en = 1'b1;
      issue(32'hC000_0024, 1'b1, 32'hFFFF_FFFF, 4'b0011);
      tick();
      check("rr_pre_busy", bus.busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rr_busy",      bus.busy, 1'b0);
      check("rr_ack",       bus.ack, 1'b0);
      check("rr_en",        bus.rom_enable, 1'b0);
      check("rr_wren",      bus.rom_wren, 1'b0);
      check("rr_addr",      bus.rom_address, 9'd0);
      check("rr_dinp",      bus.rom_dinp, 32'h0);
      check("rr_rdata",     bus.rdata, 32'h0);
      check("rr_cfg_rdata", bus.cfg_rdata, 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      tick();
      check("rr_acks",  ack_cnt - a0, 0);
      check("rr_wrs",   wren_cnt - w0, 0);
      check("rr_mem",   mem[9], 32'h5566_7788);
      check("rr_idle",  bus.busy, 1'b0);

      check("wren_without_en", bad_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1, "timeout");
   end

endmodule : tb_exprom_ctrl

// File: doc/exprom_ctrl.md
EXPROM_CTRL -- requirements
Module: exprom_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk, rst_n.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 cfg_wr  in  1  one-cycle write strobe to the expansion-ROM BAR (config offset 0x30).
REQ-005 cfg_wdata  in  32  BAR write data; cfg_be  in  4  BAR write byte enables.
REQ-006 cfg_rdata  out  32  BAR readback: {bar[31:11], 10'b0, bar_en}.
REQ-007 req  in  1  one-cycle memory transaction strobe, sampled only when busy=0.
REQ-008 req_addr  in  32; req_wr  in  1 (1=write); req_wdata  in  32; req_be  in  4.
REQ-009 prog_en  in  1  permits writes into the ROM array (shadow-programming mode).
REQ-010 hit  out  1  combinational: bar_en=1 and req_addr[31:11]=bar[31:11].
REQ-011 busy  out  1  high while FSM is not IDLE.
REQ-012 ack  out  1  one-cycle completion pulse; rdata  out  32  read data, valid while ack=1.
REQ-013 rom_address  out  9; rom_enable  out  1; rom_wren  out  1; rom_dinp  out  32; rom_dout  in  32 (synchronous 512x32 array, data valid the cycle after an enabled edge).

Function
REQ-014 BAR: bits 31:11 writable per byte lane (cfg_be[3], [2], [1] for bits 31:24, 23:16, 15:11); bit 0 (bar_en) written from cfg_wdata[0] when cfg_be[0]=1; bits 10:1 read zero.
REQ-015 cfg_wr SHALL take effect at the next edge regardless of busy; an in-flight transaction completes unaffected.
REQ-016 Word index = req_addr[10:2], latched into an address register at acceptance; req_addr[1:0] ignored.
REQ-017 Acceptance: edge E0 with req=1, busy=0, hit=1; req with hit=0 or busy=1 SHALL be ignored (no ack, no ROM activity).
REQ-018 FSM states: IDLE, RD, RD_CAP, RMW_RD, RMW_CAP, WR, DONE.
REQ-019 Read: IDLE->RD at E0; rom_enable=1, rom_wren=0 during RD; RD->RD_CAP at E1; at E2 rdata<=rom_dout, ack=1 in DONE; DONE->IDLE at E3.
REQ-020 Full write (req_be=4'hF, prog_en=1): IDLE->WR; rom_enable=rom_wren=1, rom_dinp=req_wdata during WR; ack=1 in the following DONE cycle (ack after E1).
REQ-021 Partial write (req_be not 0 and not 4'hF, prog_en=1): IDLE->RMW_RD->RMW_CAP (merge: enabled lanes from req_wdata, others from rom_dout)->WR->DONE; ack after E3.
REQ-022 Write with prog_en=0 or req_be=0: IDLE->DONE directly, no ROM access, ack after E1, array unchanged.
REQ-023 rom_enable and rom_wren SHALL be 0 in all states not named above; rom_wren never 1 without rom_enable.
REQ-024 All outputs except hit and cfg_rdata SHALL be driven from registers.
REQ-025 rdata SHALL hold its last read value until the next read capture; writes leave rdata unchanged.
REQ-026 prog_en SHALL be sampled at acceptance only; later changes do not affect an in-flight write.

Reset
REQ-027 rst_n=0 SHALL immediately force FSM=IDLE, bar=0, bar_en=0, ack=0, busy=0, rdata=0, rom_enable=0, rom_wren=0, rom_address=0, rom_dinp=0.
REQ-028 Reset mid-transaction SHALL abort it with no ack and no further ROM write.

Verification
REQ-029 cfg_wr, wdata=0xFFFF_FFFF, be=4'hF -> cfg_rdata=0xFFFF_F801; then be=4'h1, wdata=0 -> cfg_rdata=0xFFFF_F800, hit=0 for all addresses.
REQ-030 BAR=0xC000_0001, ROM word 5=0xDEAD_BEEF, read req_addr=0xC000_0014 -> rom_address=5 in RD, ack at E0+2 edge with rdata=0xDEAD_BEEF, busy low after E3.
REQ-031 prog_en=1, word 5=0x1122_3344, write be=4'b0101 wdata=0xAABB_CCDD -> one WR cycle with rom_dinp=0x11BB_33DD, ack after E3; readback=0x11BB_33DD.
REQ-032 prog_en=0, full write to word 7 -> ack after E1, rom_wren never 1, word 7 unchanged; req to 0xC000_0800 (miss) -> no ack, busy=0.
REQ-033 req during busy ignored; rst_n pulsed low in RMW_CAP -> all outputs at reset values, no ack, target word unchanged.
